// File: rtl/uart_tx_arb.sv
// uart_tx_arb
// Round-robin arbiter sharing one UART transmitter between four byte
// producers. Moves one byte at a time through the shoot/datatx/busytx
// handshake, lets the current owner lock the transmitter for multi-byte
// packets, and aborts with an error pulse if the transmitter never goes busy
// after a shoot.
//
// Ports
//   clk_i      system clock (same domain as the UART core)
//   reset_n_i  asynchronous active-low reset
//   req_i      per-requester byte valid, held with data until its gnt_o pulse
//   data_i     packed bytes, requester k on [8k+7:8k]
//   lock_i     per-requester lock request, honoured only for the owner
//   gnt_o      one-hot single-cycle pulse: the requester's byte was taken
//   owner_o    index of the last granted requester
//   err_o      single-cycle pulse when a shoot times out
//   shoot_o    single-cycle transmit strobe to the UART TX
//   datatx_o   byte to the UART TX, stable from one shoot to the next
//   busytx_i   UART TX busy
module uart_tx_arb #(
  parameter int unsigned BUSY_TIMEOUT = 64  // legal range 2..255
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [3:0]  req_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  lock_i,
  output logic [3:0]  gnt_o,
  output logic [1:0]  owner_o,
  output logic        err_o,
  output logic        shoot_o,
  output logic [7:0]  datatx_o,
  input  logic        busytx_i
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHOOT     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  // Counter value seen during the last allowed WAIT_BUSY cycle.
  localparam logic [7:0] TIMEOUT_LAST = 8'(BUSY_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [1:0] ptr_q;
  logic [1:0] owner_q;
  logic       lock_q;
  logic [7:0] cnt_q;
  logic [7:0] datatx_q;

  logic       win_valid;
  logic [1:0] win_idx;
  logic [1:0] cand;
  logic       arb_go;
  logic       timeout_hit;
  logic       lock_drop;

  // Winner selection. A held lock restricts the choice to the owner; the
  // lock flag is registered, so a lock dropped this cycle still applies.
  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    if (lock_q) begin
      win_valid = req_i[owner_q];
      win_idx   = owner_q;
    end else begin
      for (int i = 0; i < 4; i++) begin
        cand = ptr_q + 2'(i);  // wraps mod 4
        if (!win_valid && req_i[cand]) begin
          win_valid = 1'b1;
          win_idx   = cand;
        end
      end
    end
  end

  assign arb_go      = (state_q == IDLE) && !busytx_i && win_valid;
  assign timeout_hit = (state_q == WAIT_BUSY) && !busytx_i && (cnt_q == TIMEOUT_LAST);
  assign lock_drop   = lock_q && !lock_i[owner_q];

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (arb_go) state_d = SHOOT;
      SHOOT:     state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (busytx_i)         state_d = WAIT_DONE;
        else if (timeout_hit) state_d = IDLE;
      end
      WAIT_DONE: if (!busytx_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs. err_o depends on busytx_i so that a busy arriving in the last
  // allowed cycle still counts as an acknowledge.
  always_comb begin
    shoot_o  = (state_q == SHOOT);
    gnt_o    = 4'b0000;
    if (state_q == SHOOT) gnt_o = 4'b0001 << owner_q;
    err_o    = timeout_hit;
    owner_o  = owner_q;
    datatx_o = datatx_q;
  end

  // Byte and owner captured on the winning IDLE cycle; held until the next win.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      datatx_q <= 8'h00;
      owner_q  <= 2'd0;
    end else if (arb_go) begin
      datatx_q <= data_i[{win_idx, 3'b000} +: 8];
      owner_q  <= win_idx;
    end
  end

  // Round-robin pointer: next scan starts just after the granted requester.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)              ptr_q <= 2'd0;
    else if (state_q == SHOOT)   ptr_q <= owner_q + 2'd1;
  end

  // Lock flag: sampled from the owner's lock at the shoot, released as soon
  // as the owner drops its lock or the shoot times out.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                    lock_q <= 1'b0;
    else if (state_q == SHOOT)         lock_q <= lock_i[owner_q];
    else if (timeout_hit || lock_drop) lock_q <= 1'b0;
  end

  // Busy-acknowledge timeout counter; saturates instead of wrapping.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= 8'd0;
    end else if (state_q == SHOOT) begin
      cnt_q <= 8'd0;
    end else if (state_q == WAIT_BUSY && !busytx_i && cnt_q != 8'hFF) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: a fixed vector table for single byte,
// busy-at-idle and timeout, hand sequences for round robin, lock and reset
// mid-byte, then randomized traffic compared cycle by cycle with a
// behavioural model of the arbitration rules.
module tb_uart_tx_arb;

  localparam int T = 8;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  lock;
  logic        busy;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        err;
  logic        shoot;
  logic [7:0]  dtx;

  uart_tx_arb #(.BUSY_TIMEOUT(T)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .req_i     (req),
    .data_i    (data),
    .lock_i    (lock),
    .gnt_o     (gnt),
    .owner_o   (owner),
    .err_o     (err),
    .shoot_o   (shoot),
    .datatx_o  (dtx),
    .busytx_i  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  localparam int PH_IDLE = 0, PH_SHOOT = 1, PH_WB = 2, PH_WD = 3;
  int         m_ph, m_ptr, m_cnt, m_owner;
  bit         m_lock;
  logic [7:0] m_data;

  function automatic void model_reset();
    m_ph = PH_IDLE; m_ptr = 0; m_cnt = 0; m_owner = 0; m_lock = 0; m_data = 8'h00;
  endfunction

  // Expected {gnt, owner, err, shoot, datatx} for the current cycle.
  function automatic logic [15:0] model_out();
    logic       sh, e;
    logic [3:0] g;
    sh = (m_ph == PH_SHOOT);
    g  = sh ? (4'b0001 << m_owner) : 4'b0000;
    e  = (m_ph == PH_WB) && !busy && (m_cnt + 1 == T);
    return {g, 2'(m_owner), e, sh, m_data};
  endfunction

  // Apply one clock edge with the inputs currently driven.
  function automatic void model_step();
    int nph = m_ph;
    bit rel = m_lock && !lock[m_owner];
    int w   = -1;
    case (m_ph)
      PH_IDLE: begin
        if (!busy && req != 4'b0000) begin
          if (m_lock) begin
            if (req[m_owner]) w = m_owner;
          end else begin
            for (int i = 0; i < 4; i++)
              if (w < 0 && req[(m_ptr + i) % 4]) w = (m_ptr + i) % 4;
          end
        end
        if (rel) m_lock = 0;
        if (w >= 0) begin
          m_data  = data[8*w +: 8];
          m_owner = w;
          nph     = PH_SHOOT;
        end
      end
      PH_SHOOT: begin
        m_ptr  = (m_owner + 1) % 4;
        m_lock = lock[m_owner];
        m_cnt  = 0;
        nph    = PH_WB;
      end
      PH_WB: begin
        if (rel) m_lock = 0;
        if (busy) nph = PH_WD;
        else begin
          m_cnt++;
          if (m_cnt == T) begin m_lock = 0; nph = PH_IDLE; end
        end
      end
      default: begin
        if (rel) m_lock = 0;
        if (!busy) nph = PH_IDLE;
      end
    endcase
    m_ph = nph;
  endfunction

  // -------------------------------------------------------------- stimulus
  bit rand_req, rand_lock;
  int tx_wait, tx_left, tx_dmin, tx_dmax, tx_lmin, tx_lmax, timeout_pct;
  int gq[$];

  // Requesters obey the hold rule; the TX model raises busy d cycles after
  // a shoot for a random number of cycles (or too late, to force a timeout).
  task automatic stim_step(input logic [3:0] g, input logic sh);
    for (int k = 0; k < 4; k++) begin
      if (g[k]) begin
        data[8*k +: 8] = 8'($urandom);
        if (rand_req) req[k] = 1'($urandom_range(0, 1));
      end else if (rand_req && !req[k] && $urandom_range(0, 3) == 0) begin
        req[k] = 1'b1;
        data[8*k +: 8] = 8'($urandom);
      end
      if (rand_lock && $urandom_range(0, 15) == 0) lock[k] = ~lock[k];
    end
    if (sh) tx_wait = (int'($urandom_range(0, 99)) < timeout_pct) ? T + 4
                                                                  : int'($urandom_range(tx_dmin, tx_dmax));
    if (tx_left > 0) begin
      busy = 1'b1; tx_left--;
    end else if (tx_wait > 0) begin
      tx_wait--;
      if (tx_wait == 0) begin
        busy = 1'b1;
        tx_left = int'($urandom_range(tx_lmin, tx_lmax)) - 1;
      end else busy = 1'b0;
    end else busy = 1'b0;
  endtask

  // One cycle: compare at mid-cycle, step the model on the edge, then
  // drive the next inputs on the falling edge.
  task automatic run_cycle();
    logic [15:0] exp_o;
    #1;
    exp_o = model_out();
    check("outs", {16'h0, gnt, owner, err, shoot, dtx}, {16'h0, exp_o});
    for (int k = 0; k < 4; k++) if (gnt[k]) gq.push_back(k);
    @(posedge clk);
    model_step();
    @(negedge clk);
    stim_step(exp_o[15:12], exp_o[8]);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = 4'b0; lock = 4'b0; data = 32'h0; busy = 1'b0;
    tx_wait = 0; tx_left = 0; gq.delete();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------------------------------------------------------- table
  typedef struct {
    logic [3:0]  req;
    logic [3:0]  lock;
    logic        busy;
    logic [31:0] data;
    logic [3:0]  e_gnt;
    logic        e_shoot;
    logic [1:0]  e_owner;
    logic        e_err;
    logic [7:0]  e_dtx;
  } vec_t;

  function automatic vec_t mk(logic [3:0] r, logic [3:0] l, logic b, logic [31:0] d,
                              logic [3:0] g, logic s, logic [1:0] o, logic e, logic [7:0] x);
    vec_t v;
    v.req = r; v.lock = l; v.busy = b; v.data = d;
    v.e_gnt = g; v.e_shoot = s; v.e_owner = o; v.e_err = e; v.e_dtx = x;
    return v;
  endfunction

  vec_t vecs[20];

  initial begin
    int exp_rr[5] = '{0, 1, 2, 3, 0};
    int exp_lk[4] = '{1, 1, 1, 2};

    reset_n = 1'bx;
    #1;
    // Single byte from requester 2, busy window of three cycles.
    vecs[0] = mk(4'b0100, 4'b0000, 1'b0, 32'h00A5_0000, 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00);
    vecs[1] = mk(4'b0100, 4'b0000, 1'b0, 32'h00A5_0000, 4'b0100, 1'b1, 2'd2, 1'b0, 8'hA5);
    for (int i = 2; i <= 4; i++)
      vecs[i] = mk(4'b0000, 4'b0000, 1'b1, 32'h0, 4'b0000, 1'b0, 2'd2, 1'b0, 8'hA5);
    vecs[5] = mk(4'b0000, 4'b0000, 1'b0, 32'h0, 4'b0000, 1'b0, 2'd2, 1'b0, 8'hA5);
    // Busy held at idle: requester 0 waits, then is shot once busy is low.
    vecs[6] = mk(4'b0001, 4'b0000, 1'b1, 32'h0000_003C, 4'b0000, 1'b0, 2'd2, 1'b0, 8'hA5);
    vecs[7] = vecs[6];
    vecs[8] = mk(4'b0001, 4'b0000, 1'b0, 32'h0000_003C, 4'b0000, 1'b0, 2'd2, 1'b0, 8'hA5);
    vecs[9] = mk(4'b0001, 4'b0001, 1'b0, 32'h0000_003C, 4'b0001, 1'b1, 2'd0, 1'b0, 8'h3C);
    // Locked shoot never acknowledged: err in the 8th WAIT_BUSY cycle,
    // lock released, requester 1 then served normally.
    for (int i = 10; i <= 16; i++)
      vecs[i] = mk(4'b0000, 4'b0001, 1'b0, 32'h0, 4'b0000, 1'b0, 2'd0, 1'b0, 8'h3C);
    vecs[17] = mk(4'b0000, 4'b0001, 1'b0, 32'h0, 4'b0000, 1'b0, 2'd0, 1'b1, 8'h3C);
    vecs[18] = mk(4'b0010, 4'b0000, 1'b0, 32'h0000_5A00, 4'b0000, 1'b0, 2'd0, 1'b0, 8'h3C);
    vecs[19] = mk(4'b0010, 4'b0000, 1'b0, 32'h0000_5A00, 4'b0010, 1'b1, 2'd1, 1'b0, 8'h5A);

    do_reset();
    for (int i = 0; i < 20; i++) begin
      req = vecs[i].req; lock = vecs[i].lock; busy = vecs[i].busy; data = vecs[i].data;
      #1;
      check($sformatf("vec%0d", i), {16'h0, gnt, owner, err, shoot, dtx},
            {16'h0, vecs[i].e_gnt, vecs[i].e_owner, vecs[i].e_err, vecs[i].e_shoot, vecs[i].e_dtx});
      @(posedge clk);
      @(negedge clk);
    end

    // Round robin with all four requesting continuously.
    rand_req = 0; rand_lock = 0; timeout_pct = 0;
    tx_dmin = 1; tx_dmax = 1; tx_lmin = 3; tx_lmax = 3;
    do_reset();
    req = 4'b1111; data = 32'h4433_2211;
    for (int c = 0; c < 100 && gq.size() < 5; c++) run_cycle();
    check("rr_count", gq.size(), 5);
    for (int i = 0; i < 5 && i < gq.size(); i++) check($sformatf("rr_order%0d", i), gq[i], exp_rr[i]);

    // Lock: requester 1 keeps three bytes, non-owner lock 3 is ignored.
    do_reset();
    req = 4'b0010; lock = 4'b1010; data = 32'h0102_0304;
    for (int c = 0; c < 200 && gq.size() < 4; c++) begin
      run_cycle();
      if (gq.size() >= 1) req = 4'b1111;
      if (gq.size() >= 3) lock[1] = 1'b0;
    end
    check("lock_count", gq.size(), 4);
    for (int i = 0; i < 4 && i < gq.size(); i++) check($sformatf("lock_order%0d", i), gq[i], exp_lk[i]);

    // Reset in WAIT_DONE while requester 2 holds the lock.
    tx_lmin = 10; tx_lmax = 10;
    do_reset();
    req = 4'b0100; lock = 4'b0100; data = 32'h0077_0000;
    for (int c = 0; c < 50 && m_ph != PH_WD; c++) run_cycle();
    check("reached_wait_done", 32'(m_ph), 32'(PH_WD));
    run_cycle();
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_shoot", 32'(shoot), 32'h0);
    check("rst_dtx", 32'(dtx), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    model_reset();
    busy = 1'b0; tx_wait = 0; tx_left = 0; lock = 4'b0000;
    req = 4'b1101; data = 32'h5500_66EE;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    gq.delete();
    for (int c = 0; c < 20 && gq.size() < 1; c++) run_cycle();
    check("rst_first_count", gq.size(), 1);
    if (gq.size() > 0) check("rst_first_winner", gq[0], 0);

    // Randomized traffic with locks, random busy windows and timeouts.
    rand_req = 1; rand_lock = 1; timeout_pct = 10;
    tx_dmin = 1; tx_dmax = 3; tx_lmin = 1; tx_lmax = 4;
    do_reset();
    for (int c = 0; c < 3000; c++) run_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
